key_debounce: RTL and testbench

Multi-channel push-button input conditioner for the board's active-low user keys. It synchronises each raw key pin and debounces it against a 1 ms time base derived from the system clock. It then reports the clean pressed state plus single-cycle press, release and optional long-press events. It sits between the key pins and the LED/application logic, as the input-side counterpart of the LED drivers.

---
 rtl/key_pkg.sv | 19 +
 rtl/key_debounce_ch.sv | 122 ++++++++++++
 rtl/key_debounce.sv | 82 ++++++++
 tb/tb_key_debounce.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared constants and helpers for the key_debounce input conditioner.
//   MS_PER_SEC        : ticks per second of the debounce time base (1 ms)
//   DEF_*             : default configuration values for key_debounce
//   prescale_len()    : clock cycles per 1 ms tick for a given clock frequency
package key_pkg;

    localparam int unsigned MS_PER_SEC        = 1000;

    localparam int unsigned DEF_CLK_FREQ_HZ   = 50_000_000;
    localparam int unsigned DEF_NUM_KEYS      = 4;
    localparam int unsigned DEF_DEBOUNCE_MS   = 20;
    localparam int unsigned DEF_LONG_PRESS_MS = 1000;

    // Cycles per ms tick, truncated.
    function automatic int unsigned prescale_len(input int unsigned clk_freq_hz);
        return clk_freq_hz / MS_PER_SEC;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, ms-tick debouncer and optional
// long-press detector (built only when KEY_LONG_PRESS_EN is defined).
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   tick         : 1 ms time-base strobe, one cycle wide
//   key_n        : raw active-low key pin, asynchronous
//   key_level    : debounced level, 1 = pressed
//   key_press    : one-cycle pulse on accepted press
//   key_release  : one-cycle pulse on accepted release
//   key_long     : one-cycle pulse after LONG_PRESS_MS ticks held (0 if not built)
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS   = DEF_DEBOUNCE_MS
`ifdef KEY_LONG_PRESS_EN
    ,
    parameter int unsigned LONG_PRESS_MS = DEF_LONG_PRESS_MS
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_MS + 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            stable_q, stable_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            raw_c;

    // Debounce: a differing level must survive DEBOUNCE_MS ticks uninterrupted.
    always_comb begin
        sync1_d   = key_n;
        sync2_d   = sync1_q;
        stable_d  = stable_q;
        db_cnt_d  = db_cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        raw_c     = ~sync2_q;

        if (raw_c == stable_q) begin
            db_cnt_d = '0;
        end else if (tick) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_MS - 1)) begin
                stable_d  = raw_c;
                db_cnt_d  = '0;
                press_d   = raw_c;
                release_d = ~raw_c;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // Synchroniser resets to released (pin high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            stable_q  <= 1'b0;
            db_cnt_q  <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            db_cnt_q  <= db_cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_level   = stable_q;
    assign key_press   = press_q;
    assign key_release = release_q;

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_PRESS_MS + 1);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              long_q, long_d;

    // Hold counter runs only while pressed; the release cycle clears it so a
    // long pulse can never coincide with a release pulse.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        long_d     = 1'b0;

        if (!stable_q || release_d) begin
            hold_cnt_d = '0;
        end else if (tick && (hold_cnt_q != HOLD_W'(LONG_PRESS_MS))) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            long_d     = (hold_cnt_d == HOLD_W'(LONG_PRESS_MS));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q <= '0;
            long_q     <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            long_q     <= long_d;
        end
    end

    assign key_long = long_q;
`else
    assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Multi-channel debouncer for active-low push-buttons. Owns the shared 1 ms
// prescaler and instantiates one key_debounce_ch per key.
// Optional long-press events are built when KEY_LONG_PRESS_EN is defined;
// otherwise key_long is tied to 0.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   key_n        : raw active-low key pins [NUM_KEYS]
//   key_level    : debounced pressed state [NUM_KEYS]
//   key_press    : one-cycle accepted-press pulses [NUM_KEYS]
//   key_release  : one-cycle accepted-release pulses [NUM_KEYS]
//   key_long     : one-cycle long-press pulses [NUM_KEYS]
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ   = DEF_CLK_FREQ_HZ,
    parameter int unsigned NUM_KEYS      = DEF_NUM_KEYS,
    parameter int unsigned DEBOUNCE_MS   = DEF_DEBOUNCE_MS,
    parameter int unsigned LONG_PRESS_MS = DEF_LONG_PRESS_MS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    localparam int unsigned PRESCALE = prescale_len(CLK_FREQ_HZ);
    localparam int unsigned PS_W     = $clog2(PRESCALE);

    // Elaboration-time parameter sanity checks.
    if (PRESCALE < 2) begin : g_bad_clk
        $error("key_debounce: CLK_FREQ_HZ too low for a 1 ms tick");
    end
    if (NUM_KEYS < 1) begin : g_bad_keys
        $error("key_debounce: NUM_KEYS must be at least 1");
    end
    if (DEBOUNCE_MS < 1) begin : g_bad_db
        $error("key_debounce: DEBOUNCE_MS must be at least 1");
    end
    if (LONG_PRESS_MS <= DEBOUNCE_MS) begin : g_bad_long
        $error("key_debounce: LONG_PRESS_MS must exceed DEBOUNCE_MS");
    end

    logic [PS_W-1:0] ps_cnt_q, ps_cnt_d;
    logic            tick_c;

    // Prescaler: counts 0..PRESCALE-1, tick on the terminal count.
    always_comb begin
        tick_c   = (ps_cnt_q == PS_W'(PRESCALE - 1));
        ps_cnt_d = tick_c ? '0 : ps_cnt_q + PS_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_cnt_q <= '0;
        end else begin
            ps_cnt_q <= ps_cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_MS   (DEBOUNCE_MS)
`ifdef KEY_LONG_PRESS_EN
            ,
            .LONG_PRESS_MS (LONG_PRESS_MS)
`endif
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .tick        (tick_c),
            .key_n       (key_n[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with P=8, 2 keys, 4 ms debounce, 10 ms long press.
module tb_key_debounce;

    localparam int unsigned NK = 2;
`ifdef KEY_LONG_PRESS_EN
    localparam int LONG_EN = 1;
`else
    localparam int LONG_EN = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_long;

    int tests = 0;
    int fails = 0;

    key_debounce #(
        .CLK_FREQ_HZ   (8000),
        .NUM_KEYS      (NK),
        .DEBOUNCE_MS   (4),
        .LONG_PRESS_MS (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // One table step: drive key_n for 'cycles' clocks, then compare level and pulse counts.
    typedef struct {
        logic [NK-1:0] key_n;
        int            cycles;
        logic [NK-1:0] exp_level;
        int            exp_press0;
        int            exp_press1;
        int            exp_rel0;
        int            exp_rel1;
        int            exp_long;
        int            exp_both;
    } step_t;

    step_t steps[$];

    initial begin
        int n;
        int m;
        int long_cnt;
        int long_at;
        int press_extra;
        int ch1_any;
        int p0, p1, r0, r1, lg, both;
        logic [NK-1:0] press_at;
        logic [NK-1:0] rel_at;

        // Bounce: toggle key 0 every 5 cycles for 60 cycles, ending released.
        for (int i = 0; i < 12; i++) begin
            steps.push_back(step_t'{((i % 2) == 0) ? 2'b10 : 2'b11, 5, 2'b00, 0, 0, 0, 0, 0, 0});
        end
        // Settle pressed, then release.
        steps.push_back(step_t'{2'b10, 40, 2'b01, 1, 0, 0, 0, 0, 0});
        steps.push_back(step_t'{2'b11, 40, 2'b00, 0, 0, 1, 0, 0, 0});
        // Short press (6 ms), no long event.
        steps.push_back(step_t'{2'b10, 48, 2'b01, 1, 0, 0, 0, 0, 0});
        steps.push_back(step_t'{2'b11, 40, 2'b00, 0, 0, 1, 0, 0, 0});
        // Simultaneous press and release of both keys.
        steps.push_back(step_t'{2'b00, 40, 2'b11, 1, 1, 0, 0, 0, 1});
        steps.push_back(step_t'{2'b11, 40, 2'b00, 0, 0, 1, 1, 0, 0});

        // Reset state.
        rst   = 1'b1;
        key_n = 2'b11;
        repeat (3) @(negedge clk);
        check("reset_level",   int'(key_level),   0);
        check("reset_press",   int'(key_press),   0);
        check("reset_release", int'(key_release), 0);
        check("reset_long",    int'(key_long),    0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_level", int'(key_level), 0);

        // Clean press on key 0.
        key_n    = 2'b10;
        n        = 0;
        ch1_any  = 0;
        press_at = '0;
        while (n < 60 && !key_level[0]) begin
            @(negedge clk);
            n++;
            press_at = key_press;
            if (key_level[1] || key_press[1] || key_release[1] || key_long[1]) ch1_any++;
        end
        check_range("press_latency", n, 27, 34);
        check("press_pulse", int'(press_at), 1);

        // Hold 15 ms from acceptance; long pulse 80 cycles after the press pulse.
        long_cnt    = 0;
        long_at     = -1;
        press_extra = 0;
        for (m = 1; m <= 120; m++) begin
            @(negedge clk);
            if (key_long[0]) begin
                long_cnt++;
                if (long_at < 0) long_at = m;
            end
            if (key_press[0]) press_extra++;
            if (key_level[1] || key_press[1] || key_release[1] || key_long[1]) ch1_any++;
        end
        check("long_count", long_cnt, LONG_EN);
        check("long_at", long_at, (LONG_EN != 0) ? 80 : -1);
        check("press_single", press_extra, 0);
        check("held_level", int'(key_level), 1);

        // Release after long hold.
        key_n    = 2'b11;
        n        = 0;
        long_cnt = 0;
        rel_at   = '0;
        while (n < 60 && key_level[0]) begin
            @(negedge clk);
            n++;
            rel_at = key_release;
            if (key_long[0]) long_cnt++;
            if (key_level[1] || key_press[1] || key_release[1] || key_long[1]) ch1_any++;
        end
        check_range("release_latency", n, 27, 34);
        check("release_pulse", int'(rel_at), 1);
        check("no_long_on_release", long_cnt, 0);
        check("ch1_quiet", ch1_any, 0);
        repeat (10) @(negedge clk);

        // Table-driven steps.
        for (int s = 0; s < steps.size(); s++) begin
            key_n = steps[s].key_n;
            p0 = 0; p1 = 0; r0 = 0; r1 = 0; lg = 0; both = 0;
            repeat (steps[s].cycles) begin
                @(negedge clk);
                p0 += int'(key_press[0]);
                p1 += int'(key_press[1]);
                r0 += int'(key_release[0]);
                r1 += int'(key_release[1]);
                lg += int'(key_long[0]) + int'(key_long[1]);
                if (key_press == 2'b11) both++;
            end
            check($sformatf("step%0d_level", s),   int'(key_level), int'(steps[s].exp_level));
            check($sformatf("step%0d_press0", s),  p0,   steps[s].exp_press0);
            check($sformatf("step%0d_press1", s),  p1,   steps[s].exp_press1);
            check($sformatf("step%0d_rel0", s),    r0,   steps[s].exp_rel0);
            check($sformatf("step%0d_rel1", s),    r1,   steps[s].exp_rel1);
            check($sformatf("step%0d_long", s),    lg,   steps[s].exp_long);
            check($sformatf("step%0d_both", s),    both, steps[s].exp_both);
        end

        // Reset mid-qualification: key 1 accepted, key 0 two ticks in.
        key_n = 2'b01;
        repeat (40) @(negedge clk);
        check("pre_rst_level1", int'(key_level), 2);
        key_n = 2'b00;
        repeat (20) @(negedge clk);
        check("pre_rst_level0", int'(key_level), 2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_level", int'(key_level), 0);
        check("async_rst_press", int'(key_press), 0);
        repeat (3) @(negedge clk);
        check("rst_hold_level", int'(key_level), 0);
        rst = 1'b0;
        n        = 0;
        press_at = '0;
        while (n < 60 && key_level == 2'b00) begin
            @(negedge clk);
            n++;
            press_at = key_press;
        end
        check("requal_latency", n, 32);
        check("requal_level", int'(key_level), 3);
        check("requal_press", int'(press_at), 3);

        key_n = 2'b11;
        repeat (50) @(negedge clk);
        check("final_level", int'(key_level), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
